// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch unit with a DEPTH-entry prefetch queue between IMEM and decode.
// One outstanding IMEM request at a time; redirects flush the queue and drain any in-flight fetch.
module ifu_prefetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_8_out,
    output logic [CW-1:0]     q_count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t            state;
    logic [ADDR_W-1:0] fetch_pc, drop_addr, new_pc;
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic [PW-1:0]     head, tail;
    logic              push, pop;
    logic [CW-1:0]     q_pop, q_after;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign imem_req   = state != IDLE;
    assign imem_addr  = state == DROP ? drop_addr : fetch_pc;
    assign inst_valid = q_count != '0;
    assign inst_out   = inst_valid ? q_inst[head] : '0;
    assign inst_pc    = inst_valid ? q_pc[head] : '0;
    assign pc_8_out   = inst_pc + ADDR_W'(8);
    assign pop        = inst_valid & inst_ready;
    assign push       = state == WAIT & imem_ack & ~redirect;
    assign q_pop      = q_count - CW'(pop);
    assign q_after    = q_pop + CW'(push);
    assign new_pc     = {redirect_pc[ADDR_W-1:2], 2'b00};

    // The outstanding request always owns a reserved slot, so a push can never overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            q_count   <= '0;
        end else begin
            if (redirect) begin
                head    <= '0;
                tail    <= '0;
                q_count <= '0;
            end else begin
                if (push) begin
                    q_inst[tail] <= imem_data;
                    q_pc[tail]   <= fetch_pc;
                    tail         <= nxt(tail);
                end
                if (pop)
                    head <= nxt(head);
                q_count <= q_after;
            end
            case (state)
                IDLE: begin
                    if (redirect)
                        fetch_pc <= new_pc;
                    else if (q_pop < CW'(DEPTH))
                        state <= WAIT;
                end
                WAIT: begin
                    if (imem_ack && redirect) begin
                        fetch_pc <= new_pc;
                        state    <= IDLE;
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + ADDR_W'(4);
                        state    <= q_after < CW'(DEPTH) ? WAIT : IDLE;
                    end else if (redirect) begin
                        drop_addr <= fetch_pc;
                        fetch_pc  <= new_pc;
                        state     <= DROP;
                    end
                end
                default: begin
                    if (redirect)
                        fetch_pc <= new_pc;
                    if (imem_ack)
                        state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed-step bench for ifu_prefetch (DEPTH=4) with hand-computed expectations.
module tb_ifu_prefetch;
    logic        clock = 0;
    logic        reset = 1;
    logic        imem_req, imem_ack = 0, redirect = 0, inst_ready = 0, inst_valid;
    logic [31:0] imem_addr, imem_data = 0, redirect_pc = 0, inst_out, inst_pc, pc_8_out;
    logic [2:0]  q_count;
    int          checks = 0;
    int          failures = 0;

    ifu_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_ready(inst_ready), .inst_valid(inst_valid),
        .inst_out(inst_out), .inst_pc(inst_pc), .pc_8_out(pc_8_out), .q_count(q_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_qcnt", q_count, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_pc8", pc_8_out, 8);
        // test 1: in-order fetch with decode always ready
        reset = 0;
        inst_ready = 1;
        tick();
        chk("t1_req", imem_req, 1);
        chk("t1_addr0", imem_addr, 0);
        tick();
        chk("t1_addr_hold", imem_addr, 0);
        chk("t1_req_hold", imem_req, 1);
        imem_ack = 1; imem_data = 32'hD000_0000;
        tick();
        chk("t1_valid", inst_valid, 1);
        chk("t1_pc0", inst_pc, 0);
        chk("t1_inst0", inst_out, 32'hD000_0000);
        chk("t1_pc8_0", pc_8_out, 8);
        chk("t1_addr4", imem_addr, 4);
        imem_data = 32'hD000_0001;
        tick();
        chk("t1_qcnt_pushpop", q_count, 1);
        chk("t1_pc4", inst_pc, 4);
        chk("t1_inst1", inst_out, 32'hD000_0001);
        chk("t1_pc8_4", pc_8_out, 12);
        chk("t1_addr8", imem_addr, 8);
        imem_ack = 0;
        tick();
        chk("t1_empty", inst_valid, 0);
        chk("t1_req8", imem_req, 1);
        // test 2: fill the queue with decode stalled
        inst_ready = 0;
        imem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            imem_data = 32'hC000_0000 + i;
            tick();
        end
        chk("t2_full_qcnt", q_count, 4);
        chk("t2_full_req", imem_req, 0);
        imem_ack = 0;
        tick();
        tick();
        chk("t2_idle_req", imem_req, 0);
        chk("t2_idle_qcnt", q_count, 4);
        chk("t2_head_pc", inst_pc, 8);
        chk("t2_head_inst", inst_out, 32'hC000_0000);
        inst_ready = 1;
        tick();
        inst_ready = 0;
        chk("t2_pop_qcnt", q_count, 3);
        chk("t2_pop_req", imem_req, 1);
        chk("t2_pop_addr", imem_addr, 24);
        chk("t2_pop_head", inst_pc, 12);
        // test 3: redirect while waiting, late ack drained in DROP
        redirect = 1; redirect_pc = 32'h100;
        tick();
        redirect = 0;
        chk("t3_drop_req", imem_req, 1);
        chk("t3_drop_addr", imem_addr, 24);
        chk("t3_flush", q_count, 0);
        tick();
        tick();
        chk("t3_drop_hold", imem_addr, 24);
        imem_ack = 1; imem_data = 32'hDEAD_BEEF;
        tick();
        imem_ack = 0;
        chk("t3_idle_req", imem_req, 0);
        chk("t3_discard", inst_valid, 0);
        chk("t3_idle_addr", imem_addr, 32'h100);
        tick();
        chk("t3_refetch", imem_addr, 32'h100);
        chk("t3_refetch_req", imem_req, 1);
        imem_ack = 1; imem_data = 32'hE000_0000;
        tick();
        chk("t3_first_pc", inst_pc, 32'h100);
        chk("t3_first_inst", inst_out, 32'hE000_0000);
        // test 4: redirect coinciding with ack and pop, three queued
        imem_data = 32'hE000_0001;
        tick();
        imem_data = 32'hE000_0002;
        tick();
        chk("t4_qcnt3", q_count, 3);
        imem_data = 32'hBAD0_BAD0; inst_ready = 1; redirect = 1; redirect_pc = 32'h203;
        tick();
        imem_ack = 0; inst_ready = 0; redirect = 0;
        chk("t4_flush", q_count, 0);
        chk("t4_valid", inst_valid, 0);
        chk("t4_req", imem_req, 0);
        chk("t4_align", imem_addr, 32'h200);
        tick();
        chk("t4_refetch", imem_addr, 32'h200);
        // test 5: fetch address wraps past the top of memory
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 0; imem_ack = 1;
        tick();
        imem_ack = 0;
        tick();
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1; imem_data = 32'hF000_0001;
        tick();
        chk("t5_wrap_addr", imem_addr, 0);
        chk("t5_top_pc", inst_pc, 32'hFFFF_FFFC);
        chk("t5_pc8_wrap", pc_8_out, 4);
        // test 6: reset mid-request with entries queued, then reset in DROP
        imem_data = 32'hF000_0002;
        tick();
        imem_ack = 0;
        chk("t6_qcnt2", q_count, 2);
        reset = 1;
        tick();
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_qcnt", q_count, 0);
        chk("t6_rst_addr", imem_addr, 0);
        reset = 0;
        tick();
        redirect = 1; redirect_pc = 32'h40;
        tick();
        redirect = 0;
        chk("t6_in_drop", imem_addr, 0);
        reset = 1;
        tick();
        chk("t6_drop_rst_req", imem_req, 0);
        chk("t6_drop_rst_addr", imem_addr, 0);
        chk("t6_drop_rst_valid", inst_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
